// File: rtl/seq_parser_ms.sv
// seq_parser_ms
//   Parses packets made of 32-bit words: a length/stream header word, a
//   sequence-number word, then payload words. Each stream keeps the next
//   expected sequence number; packets that are in order or that follow a gap
//   are pushed into a small output queue, and stale packets are dropped.
//
// Parameters
//   NUM_STREAMS        number of tracked streams (power of 2, 2..256)
//   MAX_PAYLOAD_BYTES  largest accepted payload (1..256)
//   OUT_DEPTH          output queue entries (1..4)
//
// Ports
//   clk, reset_b                   clock, asynchronous active-low reset
//   dataIn/_val/_ready/_last       input word stream and handshake
//   dataOut/_len/_val/_ready       head-of-queue payload, byte count, handshake
//   dataOut_stream                 stream id of the head entry
//   packetLost, lostCount          head packet followed a gap / size of the gap
//   dropPulse, hdrError            one-cycle pulses: stale drop, malformed packet
//
// Build option
//   SEQ_GAP_COUNT_EN  when defined, lostCount reports the gap size; otherwise
//                     lostCount is tied to zero and its storage is removed.

module seq_parser_ms #(
  parameter int unsigned NUM_STREAMS       = 32,
  parameter int unsigned MAX_PAYLOAD_BYTES = 37,
  parameter int unsigned OUT_DEPTH         = 2
) (
  input  logic                           clk,
  input  logic                           reset_b,
  input  logic [31:0]                    dataIn,
  input  logic                           dataIn_val,
  output logic                           dataIn_ready,
  input  logic                           dataIn_last,
  output logic [8*MAX_PAYLOAD_BYTES-1:0] dataOut,
  output logic [8:0]                     dataOut_len,
  output logic                           dataOut_val,
  input  logic                           dataOut_ready,
  output logic [7:0]                     dataOut_stream,
  output logic                           packetLost,
  output logic [31:0]                    lostCount,
  output logic                           dropPulse,
  output logic                           hdrError
);

  localparam int unsigned SW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam int unsigned PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned DB = 8 * MAX_PAYLOAD_BYTES;

  typedef enum logic [1:0] {IDLE, HDR2, DATA, DISCARD} state_t;

  state_t state_q, state_d;

  logic [SW-1:0] stream_q;
  logic [31:0]   seq_q;
  logic [8:0]    rem_q;
  logic [8:0]    idx_q;
  logic [31:0]   exp_q [NUM_STREAMS];
  logic [PW-1:0] head_q, tail_q;
  logic [2:0]    cnt_q;
  logic          hdr_err_q, drop_q;

  logic [DB-1:0] q_data [OUT_DEPTH];
  logic [8:0]    q_len  [OUT_DEPTH];
  logic [SW-1:0] q_strm [OUT_DEPTH];
  logic          q_lost [OUT_DEPTH];
`ifdef SEQ_GAP_COUNT_EN
  logic [31:0]   q_cnt  [OUT_DEPTH];
`endif

  logic        xfer, start, cap_seq, wr_data, finish, err;
  logic        commit, drop_now, pop, hdr_bad, stale;
  logic [15:0] len_w;
  logic [31:0] diff;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign dataIn_ready = (cnt_q < 3'(OUT_DEPTH));
  assign dataOut_val  = (cnt_q != 3'd0);
  assign xfer         = dataIn_val & dataIn_ready;
  assign pop          = dataOut_val & dataOut_ready;
  assign len_w        = {dataIn[23:16], dataIn[31:24]};
  assign hdr_bad      = (len_w < 16'd9) || (len_w > 16'(MAX_PAYLOAD_BYTES + 8));
  // Modulo-2^32 distance; the top bit set means the packet is behind E.
  assign diff         = seq_q - exp_q[stream_q];
  assign stale        = diff[31];
  assign commit       = finish & ~stale;
  assign drop_now     = finish & stale;
  assign hdrError     = hdr_err_q;
  assign dropPulse    = drop_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    cap_seq = 1'b0;
    wr_data = 1'b0;
    finish  = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE: if (xfer) begin
        // A header that is itself marked last cannot carry a payload.
        if (hdr_bad || dataIn_last) begin
          err     = 1'b1;
          state_d = dataIn_last ? IDLE : DISCARD;
        end else begin
          start   = 1'b1;
          state_d = HDR2;
        end
      end
      HDR2: if (xfer) begin
        if (dataIn_last) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          cap_seq = 1'b1;
          state_d = DATA;
        end
      end
      DATA: if (xfer) begin
        wr_data = 1'b1;
        if (rem_q <= 9'd4) begin
          if (dataIn_last) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            err     = 1'b1;
            state_d = DISCARD;
          end
        end else if (dataIn_last) begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      DISCARD: if (xfer && dataIn_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      stream_q  <= '0;
      seq_q     <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      hdr_err_q <= 1'b0;
      drop_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_STREAMS; i++) exp_q[i] <= '0;
    end else begin
      hdr_err_q <= err;
      drop_q    <= drop_now;
      if (start) begin
        stream_q <= SW'({dataIn[7:0], dataIn[15:8]});
        rem_q    <= 9'(len_w - 16'd8);
        idx_q    <= '0;
      end
      if (cap_seq) seq_q <= {dataIn[7:0], dataIn[15:8], dataIn[23:16], dataIn[31:24]};
      if (wr_data) begin
        rem_q <= rem_q - 9'd4;
        idx_q <= idx_q + 9'd4;
      end
      if (commit) begin
        exp_q[stream_q] <= seq_q + 32'd1;
        tail_q          <= ptr_inc(tail_q);
      end
      if (pop) head_q <= ptr_inc(head_q);
      case ({commit, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Queue payload storage needs no reset: entries are only visible once
  // committed, and the tail entry is cleared when a new header arrives.
  always_ff @(posedge clk) begin
    if (start) begin
      q_data[tail_q] <= '0;
      q_len[tail_q]  <= 9'(len_w - 16'd8);
    end
    if (wr_data) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if ((b < 32'(rem_q)) && ((32'(idx_q) + b) < MAX_PAYLOAD_BYTES))
          q_data[tail_q][DB-8-8*(32'(idx_q)+b) +: 8] <= dataIn[31-8*b -: 8];
      end
    end
    if (commit) begin
      q_strm[tail_q] <= stream_q;
      q_lost[tail_q] <= (diff != 32'd0);
`ifdef SEQ_GAP_COUNT_EN
      q_cnt[tail_q]  <= diff;
`endif
    end
  end

  always_comb begin
    dataOut        = '0;
    dataOut_len    = '0;
    dataOut_stream = '0;
    packetLost     = 1'b0;
    lostCount      = '0;
    if (dataOut_val) begin
      dataOut        = q_data[head_q];
      dataOut_len    = q_len[head_q];
      dataOut_stream = 8'(q_strm[head_q]);
      packetLost     = q_lost[head_q];
`ifdef SEQ_GAP_COUNT_EN
      lostCount      = q_cnt[head_q];
`endif
    end
  end

endmodule

// File: doc/seq_parser_ms.md
SEQ_PARSER_MS -- requirements
Module: seq_parser_ms

Interface
REQ-001 Parameter NUM_STREAMS, default 32, number of tracked streams (power of 2, 2..256).
REQ-002 Parameter MAX_PAYLOAD_BYTES, default 37, largest payload accepted (1..256).
REQ-003 Parameter OUT_DEPTH, default 2, output queue entries (1..4).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset_b  in  1  asynchronous active-low reset.
REQ-006 dataIn  in  32  packet word; byte 0 = dataIn[31:24].
REQ-007 dataIn_val / dataIn_ready  in / out  1 each  input handshake; a word transfers when both are high.
REQ-008 dataIn_last  in  1  marks final word of a packet.
REQ-009 dataOut  out  8*MAX_PAYLOAD_BYTES  payload, byte 0 in MSBs, unused bytes zero.
REQ-010 dataOut_len  out  9  valid payload byte count.
REQ-011 dataOut_val / dataOut_ready  out / in  1 each  output handshake.
REQ-012 dataOut_stream  out  8  stream id of the head entry.
REQ-013 packetLost  out  1  head packet followed a sequence gap.
REQ-014 lostCount  out  32  number of missing sequence numbers before the head packet.
REQ-015 dropPulse / hdrError  out  1 each  one-cycle pulses: stale packet dropped; malformed packet discarded.

Function
REQ-016 Word 0: length L = {dataIn[23:16],dataIn[31:24]} total bytes including the 8-byte header; stream S = {dataIn[7:0],dataIn[15:8]}, low log2(NUM_STREAMS) bits used.
REQ-017 Word 1: sequence Q = byte-reversed dataIn (byte 3 most significant).
REQ-018 FSM states: IDLE -> HDR2 on word 0; HDR2 -> DATA on word 1; DATA -> IDLE on last word; any state -> DISCARD on error; DISCARD -> IDLE on the word with dataIn_last.
REQ-019 Error, detected on the offending word: L<9, L-8>MAX_PAYLOAD_BYTES, dataIn_last before byte count is exhausted, or dataIn_last absent on the word exhausting it.
REQ-020 Error response: hdrError pulses once, the partial entry is freed, expected sequences are unchanged.
REQ-021 Last data word is masked to the remaining 1-4 bytes; trailing bytes are zero.
REQ-022 Each stream keeps expected E (reset 0); D = (Q-E) mod 2^32.
REQ-023 D=0: in-order; D in [1,2^31): lost, packetLost=1, lostCount=D; otherwise stale.
REQ-024 In-order and lost packets commit to the queue and set E=Q+1 (wraps 0xFFFFFFFF->0).
REQ-025 Stale packets are not committed, E is unchanged, and dropPulse pulses in the cycle after the last word.
REQ-026 Assembly writes directly into the tail queue entry; dataIn_ready = (queue occupancy < OUT_DEPTH).
REQ-027 A commit in the same cycle as a pop is legal; occupancy is unchanged and ready stays high.
REQ-028 Commit-to-dataOut_val latency is 1 cycle.
REQ-029 dataOut, dataOut_len, dataOut_stream, packetLost and lostCount are zero whenever dataOut_val=0.
REQ-030 Output holds stable while dataOut_val=1 and dataOut_ready=0.
REQ-031 Packets from distinct streams leave in arrival order.

Reset
REQ-032 While reset_b=0: FSM=IDLE, queue empty, all E=0, and every output is 0 except dataIn_ready=1.
REQ-033 Reset mid-packet abandons the packet with no output and no pulse.

Configuration
REQ-034 Macro SEQ_GAP_COUNT_EN: when defined, lostCount reports D per REQ-023.
REQ-035 When SEQ_GAP_COUNT_EN is undefined, lostCount is tied to 0, its storage is removed, and packetLost is unaffected.

Verification
REQ-036 Stream 3, Q=0, L=13, payload AA BB CC DD EE -> dataOut_len=5, bytes AA..EE, packetLost=0, E[3]=1.
REQ-037 Stream 3, Q=5 after E=1 -> packetLost=1, lostCount=4 (0 with macro off), E[3]=6.
REQ-038 Stream 3, Q=2 after E=6 -> no output, dropPulse=1, E[3]=6.
REQ-039 dataOut_ready=0, OUT_DEPTH=2, three packets sent -> ready low after the second commit; ready rises the cycle after the first pop; order is preserved.
REQ-040 L=6 header -> hdrError=1, words discarded until dataIn_last, next valid packet parsed normally.
REQ-041 Q=0xFFFFFFFF in-order on stream 7 -> E[7]=0; next Q=0 is in-order.
